// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the MEM stage and a debug port, with a starvation bound.
// Defining DMEM_ARB_STATS_EN adds the stall_cnt counter; otherwise stall_cnt is tied to 0.
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [15:0] stall_cnt
);
  typedef enum logic {ARB, DBG_WAIT} state_t;
  state_t state, state_nx;
  logic [3:0] wait_cnt, wait_nx;
  logic dbg_sel, denied;
  assign cpu_rdata = mem_rdata;
  always_comb begin
    // reset cycles never grant debug, so no ack or stall can leak out of reset
    dbg_sel = resetn && state == ARB && dbg_req && (!cpu_req || wait_cnt == 4'(STARVE_MAX));
    denied = state == ARB && dbg_req && !dbg_sel;
    wait_nx = denied ? (wait_cnt < 4'(STARVE_MAX) ? wait_cnt + 4'd1 : wait_cnt) : '0;
    state_nx = state == ARB ? (dbg_sel ? DBG_WAIT : ARB) : (dbg_req ? DBG_WAIT : ARB);
    mem_addr = dbg_sel ? dbg_addr : cpu_addr;
    mem_wdata = dbg_sel ? dbg_wdata : cpu_wdata;
    mem_we = dbg_sel ? dbg_we : cpu_we & cpu_req;
    dbg_ack = dbg_sel;
    cpu_stall = dbg_sel & cpu_req;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ARB;
      wait_cnt <= '0;
      dbg_rdata <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_nx;
      if (dbg_sel && !dbg_we) dbg_rdata <= mem_rdata;
    end
  end
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge clock) begin
    if (!resetn) stall_q <= '0;
    else if (cpu_stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
- REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive cycles a waiting debug request may be denied by the CPU before it is forced through; legal range 1..15.
- REQ-002 SHALL have port clock  input  1: the single clock; all state updates on its rising edge.
- REQ-003 SHALL have port resetn  input  1: reset, synchronous, active-low.
- REQ-004 SHALL have port cpu_req  input  1: MEM stage requests a data-memory access this cycle.
- REQ-005 SHALL have port cpu_we  input  1: MEM stage access is a store (mwmem).
- REQ-006 SHALL have port cpu_addr  input  32: MEM stage address (malu).
- REQ-007 SHALL have port cpu_wdata  input  32: MEM stage store data (mb).
- REQ-008 SHALL have port cpu_rdata  output  32: load data to MEM stage (mmo).
- REQ-009 SHALL have port cpu_stall  output  1: freeze the pipeline this cycle.
- REQ-010 SHALL have port dbg_req  input  1: debug port request, held high until dbg_ack.
- REQ-011 SHALL have port dbg_we  input  1: debug access is a write; stable while dbg_req is high.
- REQ-012 SHALL have port dbg_addr  input  32: debug address; stable while dbg_req is high.
- REQ-013 SHALL have port dbg_wdata  input  32: debug write data; stable while dbg_req is high.
- REQ-014 SHALL have port dbg_ack  output  1: one-cycle pulse; the debug access is performed in this cycle.
- REQ-015 SHALL have port dbg_rdata  output  32: registered debug read data.
- REQ-016 SHALL have port mem_we, mem_addr, mem_wdata  output  1/32/32: data-memory write enable, address and write data.
- REQ-017 SHALL have port mem_rdata  input  32: data-memory read data, valid in the same cycle as mem_addr (RAM clocked on the inverted clock).
- REQ-018 SHALL have port stall_cnt  output  16: count of cycles with cpu_stall high.

Function
- REQ-019 SHALL implement a 2-state FSM: ARB (normal arbitration) and DBG_WAIT (an ack was issued; waiting for dbg_req to fall).
- REQ-020 SHALL maintain a 4-bit wait_cnt counting ARB cycles with dbg_req high and the debug port denied.
- REQ-021 SHALL select debug in a cycle iff state==ARB and dbg_req==1 and (cpu_req==0 or wait_cnt==STARVE_MAX); otherwise CPU is selected.
- REQ-022 When debug is selected, SHALL drive mem_addr=dbg_addr, mem_wdata=dbg_wdata, mem_we=dbg_we, and assert dbg_ack, cpu_stall=cpu_req; on the next edge, SHALL set dbg_rdata=mem_rdata if dbg_we==0 (hold otherwise), clear wait_cnt and enter DBG_WAIT.
- REQ-023 When CPU is selected, SHALL drive mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_we&cpu_req, and hold dbg_ack=0, cpu_stall=0.
- REQ-024 SHALL drive cpu_rdata=mem_rdata combinationally in every cycle (valid only when CPU is selected).
- REQ-025 In ARB, with dbg_req=1 and the debug port denied, SHALL increment wait_cnt, saturating at STARVE_MAX; with dbg_req=0, SHALL clear wait_cnt.
- REQ-026 In DBG_WAIT, SHALL select CPU unconditionally; if dbg_req==0, SHALL return to ARB on the next edge; no back-to-back debug accesses.
- REQ-027 mem_we SHALL never be 1 while the selected requester's request is 0.
- REQ-028 stall_cnt SHALL increment by 1 per cycle with cpu_stall=1, saturating at 16'hFFFF.

Reset
- REQ-029 With resetn=0 at a rising edge, SHALL set state=ARB, wait_cnt=0, dbg_rdata=0, stall_cnt=0; dbg_ack is 0 and cpu_stall is 0 during any reset cycle.
- REQ-030 If reset occurs in DBG_WAIT or with a denied debug request pending, that request SHALL NOT be treated as completed; if dbg_req is still high after reset, it SHALL be arbitrated afresh from wait_cnt=0.

Configuration
- REQ-031 Macro DMEM_ARB_STATS_EN: when defined, SHALL implement the stall_cnt counter per REQ-028; when undefined, SHALL tie stall_cnt to 0 and contain no counter logic. Arbitration is identical in both builds.

Verification
- REQ-032 cpu_req=1, cpu_we=1, cpu_addr=0x10, cpu_wdata=0xDEADBEEF, dbg_req=0 -> mem_we=1, mem_addr=0x10, cpu_stall=0, dbg_ack=0.
- REQ-033 cpu_req=0, dbg_req=1, dbg_we=0, dbg_addr=0x20, mem_rdata=0x12345678 -> dbg_ack=1 in the same cycle; dbg_rdata=0x12345678 after the edge; state=DBG_WAIT until dbg_req drops.
- REQ-034 cpu_req held at 1, dbg_req=1 from cycle 0, STARVE_MAX=4 -> cycles 0-3: CPU served, wait_cnt 1..4; cycle 4: dbg_ack=1, cpu_stall=1; cycle 5: CPU served again.
- REQ-035 dbg_req held high for 3 cycles after its ack -> no second dbg_ack until dbg_req falls and rises again.
- REQ-036 resetn=0 for one cycle in DBG_WAIT with dbg_req=1 -> state=ARB, dbg_rdata=0; with cpu_req=0, dbg_ack=1 in the first cycle after reset.
- REQ-037 With DMEM_ARB_STATS_EN defined, 3 forced debug accesses under cpu_req=1 -> stall_cnt=3; with the macro undefined -> stall_cnt=0.
